// File: rtl/riffa2ahir_bridge.sv
// RIFFA channel to AHIR pipe bridge: RX channel -> AHIR input pipe, AHIR output pipe -> TX FIFO -> TX channel.
// Optional TX padding after an empty-FIFO timeout is enabled by defining RIFFA2AHIR_TX_PAD_EN.
module riffa2ahir_bridge #(
  parameter int unsigned C_PCI_DATA_WIDTH = 32,
  parameter int unsigned TX_FIFO_DEPTH    = 4,
  parameter int unsigned TX_LEN_MODE      = 0,
  parameter int unsigned TX_DATA_LEN      = 120,
  parameter int unsigned PAD_TIMEOUT      = 256
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              CHNL_RX,
  output logic                              CHNL_RX_ACK,
  input  logic [31:0]                       CHNL_RX_LEN,
  input  logic [C_PCI_DATA_WIDTH-1:0]       CHNL_RX_DATA,
  input  logic                              CHNL_RX_DATA_VALID,
  output logic                              CHNL_RX_DATA_REN,
  output logic                              CHNL_TX,
  input  logic                              CHNL_TX_ACK,
  output logic [31:0]                       CHNL_TX_LEN,
  output logic [C_PCI_DATA_WIDTH-1:0]       CHNL_TX_DATA,
  output logic                              CHNL_TX_DATA_VALID,
  input  logic                              CHNL_TX_DATA_REN,
  output logic [C_PCI_DATA_WIDTH-1:0]       in_data_pipe_write_data,
  output logic                              in_data_pipe_write_req,
  input  logic                              in_data_pipe_write_ack,
  input  logic [C_PCI_DATA_WIDTH-1:0]       out_data_pipe_read_data,
  output logic                              out_data_pipe_read_req,
  input  logic                              out_data_pipe_read_ack,
  output logic                              rx_busy,
  output logic                              tx_busy,
  output logic [$clog2(TX_FIFO_DEPTH):0]    tx_fifo_count
);

  localparam int unsigned NUM_WORDS = C_PCI_DATA_WIDTH / 32;
  localparam int unsigned AW        = $clog2(TX_FIFO_DEPTH);
  localparam int unsigned CW        = AW + 1;

  typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  rx_state_t rx_state;
  tx_state_t tx_state;

  logic [31:0] r_len, r_count, last_rx_len;
  logic [31:0] t_len, t_count, sel_len;
  logic        rx_recv, r_more, rx_beat;
  logic        tx_send, t_more, tx_beat;

  logic [C_PCI_DATA_WIDTH-1:0] mem [TX_FIFO_DEPTH];
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [CW-1:0]               count;
  logic                        fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic                        pad_mode;
  logic                        unused_ok;

  // RX side: combinational handshake between the RIFFA channel and the AHIR input pipe
  assign rx_recv                 = (rx_state == RX_RECV);
  assign r_more                  = (r_count < r_len);
  assign in_data_pipe_write_data = CHNL_RX_DATA;
  assign in_data_pipe_write_req  = rx_recv & CHNL_RX_DATA_VALID & r_more;
  assign CHNL_RX_DATA_REN        = rx_recv & in_data_pipe_write_ack & r_more;
  assign rx_beat                 = in_data_pipe_write_req & in_data_pipe_write_ack;
  assign CHNL_RX_ACK             = rx_recv;
  assign rx_busy                 = rx_recv;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_state    <= RX_IDLE;
      r_len       <= '0;
      r_count     <= '0;
      last_rx_len <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (CHNL_RX) begin
            r_len    <= CHNL_RX_LEN;
            r_count  <= '0;
            rx_state <= RX_RECV;
          end
        end
        RX_RECV: begin
          if (!r_more) begin
            last_rx_len <= r_len;
            rx_state    <= RX_IDLE;
          end else if (rx_beat) begin
            r_count <= r_count + 32'(NUM_WORDS);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // TX FIFO: first-word-fall-through, head is visible whenever non-empty
  assign fifo_empty             = (count == '0);
  assign fifo_full              = (count == CW'(TX_FIFO_DEPTH));
  assign out_data_pipe_read_req = !fifo_full;
  assign fifo_push              = !fifo_full & out_data_pipe_read_ack;
  assign tx_fifo_count          = count;

  always_ff @(posedge CLK) begin
    if (fifo_push) mem[wr_ptr] <= out_data_pipe_read_data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + AW'(1);
      if (fifo_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // TX side: length selection, beat handshake, pad beats bypass the FIFO
  assign sel_len            = (TX_LEN_MODE == 0) ? 32'(TX_DATA_LEN) : last_rx_len;
  assign tx_send            = (tx_state == TX_SEND);
  assign t_more             = (t_count < t_len);
  assign CHNL_TX_DATA_VALID = tx_send & t_more & (pad_mode | !fifo_empty);
  assign fifo_pop           = tx_send & t_more & !pad_mode & !fifo_empty & CHNL_TX_DATA_REN;
  assign tx_beat            = CHNL_TX_DATA_VALID & CHNL_TX_DATA_REN;
  assign CHNL_TX_DATA       = (pad_mode || fifo_empty) ? '0 : mem[rd_ptr];
  assign CHNL_TX            = tx_send;
  assign CHNL_TX_LEN        = t_len;
  assign tx_busy            = tx_send;

  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_state <= TX_IDLE;
      t_len    <= '0;
      t_count  <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          t_count <= '0;
          if (!fifo_empty && (sel_len != '0)) begin
            t_len    <= sel_len;
            tx_state <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (!t_more) begin
            tx_state <= TX_IDLE;
          end else if (tx_beat) begin
            t_count <= t_count + 32'(NUM_WORDS);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

`ifdef RIFFA2AHIR_TX_PAD_EN
  localparam int unsigned PW = $clog2(PAD_TIMEOUT + 1);
  logic [PW-1:0] pad_cnt;

  // Enter pad mode after PAD_TIMEOUT consecutive empty cycles while sending
  always_ff @(posedge CLK) begin
    if (RST || !tx_send) begin
      pad_mode <= 1'b0;
      pad_cnt  <= '0;
    end else if (!pad_mode) begin
      if (fifo_empty) begin
        if (pad_cnt == PW'(PAD_TIMEOUT - 1)) pad_mode <= 1'b1;
        else                                 pad_cnt  <= pad_cnt + PW'(1);
      end else begin
        pad_cnt <= '0;
      end
    end
  end
`else
  assign pad_mode = 1'b0;
`endif

  // TX_ACK is informational only
  assign unused_ok = ^{CHNL_TX_ACK, 32'(PAD_TIMEOUT)};

endmodule

// File: tb/tb_riffa2ahir_bridge.sv
// Directed bench for riffa2ahir_bridge: a 32-bit mode-0 instance and a 64-bit mode-1 instance.
module tb_riffa2ahir_bridge;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // instance a: W=32, fixed TX length 4
  logic        a_rx, a_rx_ack, a_rx_valid, a_rx_ren;
  logic [31:0] a_rx_len, a_rx_data, a_tx_len, a_tx_data, a_wdata, a_rdata;
  logic        a_tx, a_tx_ack, a_tx_valid, a_tx_ren;
  logic        a_wreq, a_wack, a_rreq, a_rack, a_rx_busy, a_tx_busy;
  logic [2:0]  a_cnt;

  // instance b: W=64, echo RX length
  logic        b_rx, b_rx_ack, b_rx_valid, b_rx_ren;
  logic [31:0] b_rx_len, b_tx_len;
  logic [63:0] b_rx_data, b_tx_data, b_wdata, b_rdata;
  logic        b_tx, b_tx_ack, b_tx_valid, b_tx_ren;
  logic        b_wreq, b_wack, b_rreq, b_rack, b_rx_busy, b_tx_busy;
  logic [2:0]  b_cnt;

  riffa2ahir_bridge #(.C_PCI_DATA_WIDTH(32), .TX_FIFO_DEPTH(4), .TX_LEN_MODE(0), .TX_DATA_LEN(4)) u_a (
    .CLK(clk), .RST(rst),
    .CHNL_RX(a_rx), .CHNL_RX_ACK(a_rx_ack), .CHNL_RX_LEN(a_rx_len), .CHNL_RX_DATA(a_rx_data),
    .CHNL_RX_DATA_VALID(a_rx_valid), .CHNL_RX_DATA_REN(a_rx_ren),
    .CHNL_TX(a_tx), .CHNL_TX_ACK(a_tx_ack), .CHNL_TX_LEN(a_tx_len), .CHNL_TX_DATA(a_tx_data),
    .CHNL_TX_DATA_VALID(a_tx_valid), .CHNL_TX_DATA_REN(a_tx_ren),
    .in_data_pipe_write_data(a_wdata), .in_data_pipe_write_req(a_wreq), .in_data_pipe_write_ack(a_wack),
    .out_data_pipe_read_data(a_rdata), .out_data_pipe_read_req(a_rreq), .out_data_pipe_read_ack(a_rack),
    .rx_busy(a_rx_busy), .tx_busy(a_tx_busy), .tx_fifo_count(a_cnt)
  );

  riffa2ahir_bridge #(.C_PCI_DATA_WIDTH(64), .TX_FIFO_DEPTH(4), .TX_LEN_MODE(1), .TX_DATA_LEN(120)) u_b (
    .CLK(clk), .RST(rst),
    .CHNL_RX(b_rx), .CHNL_RX_ACK(b_rx_ack), .CHNL_RX_LEN(b_rx_len), .CHNL_RX_DATA(b_rx_data),
    .CHNL_RX_DATA_VALID(b_rx_valid), .CHNL_RX_DATA_REN(b_rx_ren),
    .CHNL_TX(b_tx), .CHNL_TX_ACK(b_tx_ack), .CHNL_TX_LEN(b_tx_len), .CHNL_TX_DATA(b_tx_data),
    .CHNL_TX_DATA_VALID(b_tx_valid), .CHNL_TX_DATA_REN(b_tx_ren),
    .in_data_pipe_write_data(b_wdata), .in_data_pipe_write_req(b_wreq), .in_data_pipe_write_ack(b_wack),
    .out_data_pipe_read_data(b_rdata), .out_data_pipe_read_req(b_rreq), .out_data_pipe_read_ack(b_rack),
    .rx_busy(b_rx_busy), .tx_busy(b_tx_busy), .tx_fifo_count(b_cnt)
  );

  typedef struct {
    logic        rx;
    logic [31:0] len;
    logic        valid;
    logic        wack;
    logic [3:0]  exp;   // {rx_ack, rx_ren, write_req, rx_busy}
  } rx_vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] bword(input int k);
    return {32'hB000_0000 + 32'(k), 32'hC000_0000 + 32'(k)};
  endfunction

  rx_vec_t tab[$];

  initial begin
    int pi, po, txn, beats1, beats2, xfers;
    logic prev_tx;

    rst = 1'b1;
    a_rx = 0; a_rx_len = '0; a_rx_data = '0; a_rx_valid = 0; a_tx_ack = 0; a_tx_ren = 0;
    a_wack = 0; a_rdata = '0; a_rack = 0;
    b_rx = 0; b_rx_len = '0; b_rx_data = '0; b_rx_valid = 0; b_tx_ack = 0; b_tx_ren = 0;
    b_wack = 0; b_rdata = '0; b_rack = 0;

    // reset state
    next(); next();
    chk("rst_a_flags", 64'({a_rx_ack, a_rx_ren, a_tx, a_tx_valid, a_wreq, a_rreq, a_rx_busy, a_tx_busy}), 64'h04);
    chk("rst_a_len_data_cnt", {a_tx_len, a_tx_data[28:0], a_cnt}, 64'h0);
    chk("rst_b_flags", 64'({b_rx_ack, b_rx_ren, b_tx, b_tx_valid, b_wreq, b_rreq, b_rx_busy, b_tx_busy}), 64'h04);
    chk("rst_b_len_cnt", 64'({b_tx_len, b_cnt}), 64'h0);
    chk("rst_b_data", b_tx_data, 64'h0);
    rst = 1'b0;

    // RX vectors on instance a (one word per beat)
    tab.push_back('{1'b1, 32'd8, 1'b0, 1'b0, 4'b0000});
    for (int i = 0; i < 8; i++) tab.push_back('{1'b1, 32'd8, 1'b1, 1'b1, 4'b1111});
    tab.push_back('{1'b0, 32'd8, 1'b1, 1'b1, 4'b1001});
    tab.push_back('{1'b0, 32'd0, 1'b0, 1'b0, 4'b0000});
    tab.push_back('{1'b1, 32'd0, 1'b1, 1'b1, 4'b0000});
    tab.push_back('{1'b0, 32'd0, 1'b1, 1'b1, 4'b1001});
    tab.push_back('{1'b0, 32'd0, 1'b0, 1'b0, 4'b0000});
    tab.push_back('{1'b1, 32'd2, 1'b0, 1'b0, 4'b0000});
    tab.push_back('{1'b0, 32'd2, 1'b0, 1'b1, 4'b1101});
    tab.push_back('{1'b0, 32'd2, 1'b1, 1'b0, 4'b1011});
    tab.push_back('{1'b0, 32'd2, 1'b1, 1'b1, 4'b1111});
    tab.push_back('{1'b0, 32'd2, 1'b1, 1'b1, 4'b1111});
    tab.push_back('{1'b0, 32'd2, 1'b1, 1'b1, 4'b1001});
    tab.push_back('{1'b0, 32'd0, 1'b0, 1'b0, 4'b0000});
    for (int i = 0; i < tab.size(); i++) begin
      next();
      a_rx = tab[i].rx; a_rx_len = tab[i].len; a_rx_valid = tab[i].valid; a_wack = tab[i].wack;
      a_rx_data = 32'hD000_0000 + 32'(i);
      #2;
      chk($sformatf("rx_vec%0d", i), 64'({a_rx_ack, a_rx_ren, a_wreq, a_rx_busy}), 64'(tab[i].exp));
      if (tab[i].exp[1]) chk($sformatf("rx_data%0d", i), 64'(a_wdata), 64'(32'hD000_0000 + 32'(i)));
    end
    next();
    a_rx = 0; a_rx_valid = 0; a_wack = 0;

    // TX stream on instance a: six words, fixed length 4 -> 4 beats then a second transaction
    pi = 0; po = 0; txn = 0; beats1 = 0; beats2 = 0; prev_tx = 1'b0;
    a_tx_ren = 1'b1;
    for (int c = 0; c < 14; c++) begin
      next();
      a_rack  = (pi < 6);
      a_rdata = 32'hA0 + 32'(pi);
      #2;
      if (a_tx && !prev_tx) begin
        txn++;
        chk("tx_len_txn", 64'(a_tx_len), 64'd4);
      end
      prev_tx = a_tx;
      if (a_tx_valid) begin
        chk("tx_data", 64'(a_tx_data), 64'(32'hA0 + 32'(po)));
        po++;
        if (txn == 1) beats1++;
        if (txn == 2) beats2++;
      end
      if (a_rreq && a_rack) pi++;
    end
    chk("tx_words_out", 64'(po), 64'd6);
    chk("tx_txn_count", 64'(txn), 64'd2);
    chk("tx_beats_first", 64'(beats1), 64'd4);
    chk("tx_beats_second", 64'(beats2), 64'd2);
    chk("tx_wait_state", 64'({a_tx_busy, a_tx_valid, a_cnt}), 64'({1'b1, 1'b0, 3'd0}));

    // mode 1 on instance b: no TX before an RX has completed
    a_tx_ren = 1'b0; a_rack = 1'b0;
    for (int p = 0; p < 3; p++) begin
      next();
      b_rack = 1'b1; b_rdata = bword(p);
      #2;
      chk("b_fill_req", 64'(b_rreq), 64'd1);
    end
    next();
    b_rack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      next(); #2;
      chk("b_no_tx_before_rx", 64'(b_tx), 64'd0);
    end
    chk("b_cnt_3", 64'(b_cnt), 64'd3);

    // RX of length 5 at 64 bits with toggling write_ack
    next();
    b_rx = 1'b1; b_rx_len = 32'd5; b_rx_valid = 1'b1; b_wack = 1'b0;
    #2;
    chk("b_rx_idle_ack", 64'(b_rx_ack), 64'd0);
    xfers = 0;
    for (int k = 0; k < 6; k++) begin
      next();
      b_rx = 1'b0;
      b_wack = (k == 5) || (k % 2 == 0);
      b_rx_data = 64'h1111_0000_0000_0000 + 64'(k);
      #2;
      chk($sformatf("b_rx_k%0d", k), 64'({b_rx_ack, b_rx_ren, b_wreq}),
          64'({1'b1, (k < 5) && (k % 2 == 0), k < 5}));
      if (k == 1) chk("b_wdata", b_wdata, 64'h1111_0000_0000_0001);
      if (b_wreq && b_wack) xfers++;
    end
    next();
    b_rx_valid = 1'b0; b_wack = 1'b0;
    #2;
    chk("b_rx_done", 64'({b_rx_busy, b_tx}), 64'd0);
    chk("b_rx_beats", 64'(xfers), 64'd3);
    next(); #2;
    chk("b_tx_start", 64'({b_tx, b_tx_busy}), 64'd3);
    chk("b_tx_len_echo", 64'(b_tx_len), 64'd5);
    po = 0;
    b_tx_ren = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) next();
      #2;
      if (b_tx_valid) begin
        chk("b_tx_data", b_tx_data, bword(po));
        po++;
      end
    end
    chk("b_tx_beats", 64'(po), 64'd3);
    chk("b_tx_end", 64'({b_tx, b_cnt}), 64'd0);
    b_tx_ren = 1'b0;

    // FIFO full with REN low, then pop-only, then push and pop together, then reset mid-SEND
    for (int d = 0; d < 4; d++) begin
      next();
      a_rack = 1'b1; a_rdata = 32'hE0 + 32'(d);
      #2;
      chk("fill_req", 64'(a_rreq), 64'd1);
    end
    next(); #2;
    chk("full_cnt", 64'(a_cnt), 64'd4);
    chk("full_req", 64'(a_rreq), 64'd0);
    chk("full_head", 64'({a_tx_valid, a_tx_data}), 64'({1'b1, 32'hE0}));
    a_tx_ren = 1'b1;
    next(); #2;
    chk("pop_only", 64'({a_cnt, a_rreq}), 64'({3'd3, 1'b1}));
    next();
    a_tx_ren = 1'b0; a_rack = 1'b0;
    #2;
    chk("push_pop_same", 64'(a_cnt), 64'd3);
    next(); #2;
    chk("tx_drop", 64'(a_tx), 64'd0);
    next(); #2;
    chk("tx_resend", 64'(a_tx), 64'd1);
    rst = 1'b1;
    next();
    rst = 1'b0;
    #2;
    chk("rst_mid_send", 64'({a_cnt, a_tx, a_tx_busy, a_rreq}), 64'({3'd0, 1'b0, 1'b0, 1'b1}));
    chk("rst_mid_len", 64'(a_tx_len), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
